uart_rx_fifo: RTL
=================

Name: uart_rx_fifo

Overview:
- Receive end of the board UART line; deserialises 8N1 frames arriving on the FPGA UART_RX pin into bytes for the uCup system.
- Samples at 16x oversampling and buffers received bytes in a small FIFO.
- Presents the FIFO head on a valid/ready interface.
- Reports sticky framing-error and overflow flags.

Parameters:
- ClockFrequency, 50_000_000, clk_sys_i frequency in Hz.
- BaudRate, 115_200, line rate in bit/s.
- FifoDepth, 8, number of byte entries; power of two, minimum 2.
- Derived: ClksPerTick = round(ClockFrequency / (16*BaudRate)), minimum 1.

Ports:
- clk_sys_i  input  1  system clock.
- rst_sys_ni  input  1  asynchronous active-low reset.
- rx_i  input  1  raw serial line, idle high, asynchronous to clk_sys_i.
- rx_data_o  output  8  FIFO head byte.
- rx_valid_o  output  1  FIFO non-empty.
- rx_ready_i  input  1  consumer pops the head when rx_valid_o&rx_ready_i.
- fifo_level_o  output  $clog2(FifoDepth)+1  current entry count.
- frame_err_o  output  1  sticky: stop bit sampled low.
- overflow_o  output  1  sticky: byte dropped because FIFO full.
- clr_err_i  input  1  one-cycle pulse clears both sticky flags.

Behaviour:
- Reset:
  - 2-FF synchroniser on rx_i, both stages reset to 1.
  - FSM resets to IDLE; tick counter, bit counter and shift register reset to 0.
  - FIFO resets empty.
  - rx_data_o=0, rx_valid_o=0, fifo_level_o=0, frame_err_o=0, overflow_o=0.
  - Reset mid-frame abandons the partial byte; FIFO contents are lost.
- Tick generator: free-running counter 0..ClksPerTick-1; tick pulses one cycle at wrap. It restarts at 0 on the IDLE->START transition.
- FSM (all decisions use the synchronised line, rxs):
  - IDLE: rxs==0 -> START.
  - START: after 8 ticks (mid start bit), sample rxs. 1 -> IDLE (glitch rejected, no flag). 0 -> DATA, bit counter=0.
  - DATA: every 16 ticks, sample rxs into the shift register, LSB first. After the 8th bit -> STOP.
  - STOP: after 16 ticks, sample rxs.
    - 1: push the byte, -> IDLE.
    - 0: set frame_err_o, discard the byte, -> BREAK.
  - BREAK: wait for rxs==1, then -> IDLE. A held-low line (break condition) produces exactly one frame error.
- Latency:
  - A byte is pushed in the cycle after the stop-bit sample.
  - rx_valid_o and rx_data_o reflect it in the cycle after the push.
  - Total from mid-stop-bit to visible output is at most 3 clk_sys_i cycles, plus 2 cycles of synchroniser delay on the line itself.
- FIFO:
  - Show-ahead: rx_data_o always equals the oldest entry while rx_valid_o=1. rx_data_o is don't-care but stable while empty.
  - Pop when rx_valid_o&rx_ready_i.
  - A push is accepted when level<FifoDepth, or when a pop occurs in the same cycle.
  - If neither holds, the byte is dropped and overflow_o is set; FIFO contents are unchanged.
  - Simultaneous push and pop leaves the level unchanged.
  - Pointers wrap modulo FifoDepth.
  - rx_ready_i while empty has no effect.
- Sticky flags:
  - Set on their event; cleared by clr_err_i.
  - If an event and clr_err_i coincide in the same cycle, the set wins.
- rx_data_o, rx_valid_o and fifo_level_o are registered outputs.

Test Plan:
All tests use ClockFrequency=7_372_800 and BaudRate=115_200, giving ClksPerTick=4 and 64 clocks per bit.
1. Single frame 0xA5, rx_ready_i=0 -> after the stop bit: rx_valid_o=1, rx_data_o=0xA5, fifo_level_o=1, no flags. Then one cycle of rx_ready_i=1 -> rx_valid_o=0, level 0.
2. Back-to-back frames 0x00, 0xFF, 0x55 with no idle gap, rx_ready_i=0 -> level 3; pops return 0x00, 0xFF, 0x55 in order.
3. 10 frames 0x01..0x0A with rx_ready_i=0 (FifoDepth=8) -> level 8, overflow_o=1; pops return 0x01..0x08 only. Then clr_err_i pulse -> overflow_o=0.
4. FIFO full while the 9th stop bit completes, with rx_ready_i=1 held in that push cycle -> push accepted, level stays 8, overflow_o=0; the last entry is the 9th byte.
5. Frame 0x3C with stop bit driven low, then line held low for 30 bit times, then high, then a valid 0x3C -> frame_err_o=1 exactly once, level=1, data=0x3C.
6. 20-clock low glitch on idle line -> START rejects it: no push, no flags, FSM returns to IDLE. Assert rst_sys_ni mid-DATA -> all outputs go to reset values immediately; the next full frame is received correctly.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling, feeding a show-ahead byte FIFO.
// Sticky framing-error and overflow flags are cleared by clr_err_i; a coincident event wins.
module uart_rx_fifo #(
    parameter int unsigned ClockFrequency = 50_000_000,
    parameter int unsigned BaudRate       = 115_200,
    parameter int unsigned FifoDepth      = 8
) (
    input  logic                         clk_sys_i,
    input  logic                         rst_sys_ni,
    input  logic                         rx_i,
    output logic [7:0]                   rx_data_o,
    output logic                         rx_valid_o,
    input  logic                         rx_ready_i,
    output logic [$clog2(FifoDepth):0]   fifo_level_o,
    output logic                         frame_err_o,
    output logic                         overflow_o,
    input  logic                         clr_err_i
);

    localparam int unsigned ClksRaw     = (ClockFrequency + 8 * BaudRate) / (16 * BaudRate);
    localparam int unsigned ClksPerTick = (ClksRaw < 1) ? 1 : ClksRaw;
    localparam int unsigned TickW       = (ClksPerTick > 1) ? $clog2(ClksPerTick) : 1;
    localparam int unsigned PtrW        = $clog2(FifoDepth);
    localparam int unsigned LvlW        = PtrW + 1;
    localparam logic [TickW-1:0] TickMax = TickW'(ClksPerTick - 1);
    localparam logic [LvlW-1:0]  LvlFull = LvlW'(FifoDepth);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_e;

    logic [1:0]       sync_q;
    logic             rxs;
    logic [TickW-1:0] tick_cnt_q;
    logic             tick;
    state_e           state_q;
    logic [3:0]       sub_cnt_q;
    logic [2:0]       bit_cnt_q;
    logic [7:0]       shift_q;
    logic             push_q;
    logic             frame_err_q;

    assign rxs  = sync_q[1];
    assign tick = (tick_cnt_q == TickMax);

    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx_i};
        end
    end

    // Restarting on the falling edge aligns ticks to the start bit.
    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            tick_cnt_q <= '0;
        end else if ((state_q == IDLE && !rxs) || tick) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            state_q     <= IDLE;
            sub_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            push_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            push_q <= 1'b0;
            if (clr_err_i) begin
                frame_err_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (!rxs) begin
                        state_q   <= START;
                        sub_cnt_q <= '0;
                    end
                end
                START: begin
                    if (tick) begin
                        if (sub_cnt_q == 4'd7) begin
                            sub_cnt_q <= '0;
                            if (rxs) begin
                                state_q <= IDLE;
                            end else begin
                                state_q   <= DATA;
                                bit_cnt_q <= '0;
                            end
                        end else begin
                            sub_cnt_q <= sub_cnt_q + 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        sub_cnt_q <= sub_cnt_q + 4'd1;
                        if (sub_cnt_q == 4'd15) begin
                            shift_q   <= {rxs, shift_q[7:1]};
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                state_q <= STOP;
                            end
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        sub_cnt_q <= sub_cnt_q + 4'd1;
                        if (sub_cnt_q == 4'd15) begin
                            if (rxs) begin
                                push_q  <= 1'b1;
                                state_q <= IDLE;
                            end else begin
                                frame_err_q <= 1'b1;
                                state_q     <= BREAK;
                            end
                        end
                    end
                end
                BREAK: begin
                    if (rxs) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    logic [7:0]      mem [FifoDepth];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_nxt;
    logic [LvlW-1:0] level_q, level_nxt;
    logic            valid_q;
    logic [7:0]      data_q, data_nxt;
    logic            overflow_q;
    logic            pop, push_ok;

    assign pop     = valid_q & rx_ready_i;
    assign push_ok = push_q & ((level_q != LvlFull) | pop);

    // Head register is computed from post-update pointers; bypass the write when the new head is the slot being written.
    always_comb begin
        rd_ptr_nxt = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_nxt  = level_q;
        if (push_ok && !pop) begin
            level_nxt = level_q + 1'b1;
        end else if (!push_ok && pop) begin
            level_nxt = level_q - 1'b1;
        end
        data_nxt = data_q;
        if (level_nxt != '0) begin
            if (push_ok && (wr_ptr_q == rd_ptr_nxt)) begin
                data_nxt = shift_q;
            end else begin
                data_nxt = mem[rd_ptr_nxt];
            end
        end
    end

    always_ff @(posedge clk_sys_i) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= shift_q;
        end
    end

    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            rd_ptr_q <= rd_ptr_nxt;
            level_q  <= level_nxt;
            valid_q  <= (level_nxt != '0);
            data_q   <= data_nxt;
            if (clr_err_i) begin
                overflow_q <= 1'b0;
            end
            if (push_q && !push_ok) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign rx_data_o    = data_q;
    assign rx_valid_o   = valid_q;
    assign fifo_level_o = level_q;
    assign frame_err_o  = frame_err_q;
    assign overflow_o   = overflow_q;

endmodule
